ex_mem_stage: RTL and testbench

//  EX/MEM pipeline stage directly downstream of the EX-stage ALU in the pipelined CPU.

---
 rtl/ex_mem_stage.sv | 118 +++++++++++
 tb/tb_ex_mem_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: latches ALU results, issues loads/stores to the D-cache, stalls EX while
// a cache access is outstanding. Optional misaligned-access trap under EXMEM_MISALIGN_TRAP_EN.
module ex_mem_stage #(
  parameter int unsigned bit_size = 32,
  parameter int unsigned reg_bits = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [bit_size-1:0] ALUOut,
  input  logic                Zero,
  input  logic [bit_size-1:0] ex_WD,
  input  logic [reg_bits-1:0] ex_WR,
  input  logic                ex_RegWrite,
  input  logic                ex_MemRead,
  input  logic                ex_MemWrite,
  input  logic                ex_Branch,
  input  logic                flush,
  output logic                ex_stall,
  output logic                BranchTaken,
  output logic                DC_req,
  output logic                DC_we,
  output logic [bit_size-1:0] DC_addr,
  output logic [bit_size-1:0] DC_wdata,
  input  logic                DC_ready,
  input  logic [bit_size-1:0] DC_rdata,
  output logic                wb_valid,
  output logic                wb_RegWrite,
  output logic [reg_bits-1:0] wb_WR,
  output logic [bit_size-1:0] wb_Data,
  output logic                misalign
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q;
  logic                m_valid_q;
  logic                regwrite_q;
  logic                load_q;
  logic                we_q;
  logic                misalign_q;
  logic [reg_bits-1:0] wr_q;
  logic [bit_size-1:0] data_q;
  logic [bit_size-1:0] addr_q;
  logic [bit_size-1:0] wdata_q;

  logic accept;
  logic is_mem;
  logic trap;

  assign accept = ex_valid & ~flush;
  assign is_mem = ex_MemRead | ex_MemWrite;

`ifdef EXMEM_MISALIGN_TRAP_EN
  assign trap = is_mem & (|ALUOut[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      m_valid_q  <= 1'b0;
      regwrite_q <= 1'b0;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      wr_q       <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          m_valid_q  <= 1'b0;
          misalign_q <= 1'b0;
          if (accept) begin
            wr_q       <= ex_WR;
            data_q     <= ALUOut;
            addr_q     <= {ALUOut[bit_size-1:2], 2'b00};
            wdata_q    <= ex_WD;
            we_q       <= ex_MemWrite;
            load_q     <= ex_MemRead & ~ex_MemWrite;
            // Stores and trapped accesses never write the register file.
            regwrite_q <= ex_RegWrite & ~ex_MemWrite & ~trap;
            misalign_q <= trap;
            if (is_mem && !trap) begin
              state_q <= StReq;
            end else begin
              m_valid_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (DC_ready) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b1;
            if (load_q) data_q <= DC_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ex_stall    = (state_q == StReq);
  assign DC_req      = (state_q == StReq);
  assign DC_we       = we_q;
  assign DC_addr     = addr_q;
  assign DC_wdata    = wdata_q;
  assign BranchTaken = ex_valid & ex_Branch & Zero & ~flush;
  assign wb_valid    = m_valid_q;
  assign wb_RegWrite = regwrite_q;
  assign wb_WR       = wr_q;
  assign wb_Data     = data_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; honours EXMEM_MISALIGN_TRAP_EN when defined.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, Zero, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, flush;
  logic [31:0] ALUOut, ex_WD, DC_rdata;
  logic [4:0]  ex_WR;
  logic        DC_ready;
  logic        ex_stall, BranchTaken, DC_req, DC_we, wb_valid, wb_RegWrite, misalign;
  logic [31:0] DC_addr, DC_wdata, wb_Data;
  logic [4:0]  wb_WR;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_stage #(.bit_size(32), .reg_bits(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALUOut(ALUOut), .Zero(Zero), .ex_WD(ex_WD),
    .ex_WR(ex_WR), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .flush(flush), .ex_stall(ex_stall),
    .BranchTaken(BranchTaken), .DC_req(DC_req), .DC_we(DC_we), .DC_addr(DC_addr),
    .DC_wdata(DC_wdata), .DC_ready(DC_ready), .DC_rdata(DC_rdata), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_WR(wb_WR), .wb_Data(wb_Data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ALUOut = 0; Zero = 0; ex_WD = 0; ex_WR = 0; ex_RegWrite = 0;
    ex_MemRead = 0; ex_MemWrite = 0; ex_Branch = 0; flush = 0; DC_ready = 0; DC_rdata = 0;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                        input logic mr, input logic mw, input logic [31:0] wd);
    ex_valid = 1; ALUOut = alu; ex_WR = wr; ex_RegWrite = rw;
    ex_MemRead = mr; ex_MemWrite = mw; ex_WD = wd; flush = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    check("rst_wb_valid", {31'd0, wb_valid}, 0);
    check("rst_dc_req", {31'd0, DC_req}, 0);
    check("rst_stall", {31'd0, ex_stall}, 0);
    check("rst_wb_data", wb_Data, 0);
    tick(); tick();
    rst = 0;
    tick();

    // 1: R-type retires one cycle after accept
    set_op(32'h5, 5'd3, 1, 0, 0, 0);
    #1 check("t1_stall", {31'd0, ex_stall}, 0);
    tick();
    check("t1_wb_valid", {31'd0, wb_valid}, 1);
    check("t1_wb_data", wb_Data, 32'h5);
    check("t1_wb_wr", {27'd0, wb_WR}, 3);
    check("t1_wb_rw", {31'd0, wb_RegWrite}, 1);
    check("t1_stall2", {31'd0, ex_stall}, 0);
    idle_inputs();
    tick();
    check("t1_wb_pulse", {31'd0, wb_valid}, 0);

    // 2: load with three REQ cycles; EX inputs change during REQ
    set_op(32'h40, 5'd7, 1, 1, 0, 0);
    tick();
    ex_valid = 1; ALUOut = 32'h999; ex_MemRead = 0;
    for (int i = 0; i < 3; i++) begin
      check("t2_req", {31'd0, DC_req}, 1);
      check("t2_stall", {31'd0, ex_stall}, 1);
      check("t2_addr", DC_addr, 32'h40);
      check("t2_we", {31'd0, DC_we}, 0);
      check("t2_wb_valid_req", {31'd0, wb_valid}, 0);
      DC_ready = (i == 2);
      DC_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      tick();
    end
    DC_ready = 0;
    check("t2_req_done", {31'd0, DC_req}, 0);
    check("t2_stall_done", {31'd0, ex_stall}, 0);
    check("t2_wb_valid", {31'd0, wb_valid}, 1);
    check("t2_wb_data", wb_Data, 32'hDEADBEEF);
    check("t2_wb_wr", {27'd0, wb_WR}, 7);
    check("t2_wb_rw", {31'd0, wb_RegWrite}, 1);
    // Accept in the same cycle the load result is shown
    set_op(32'h77, 5'd9, 1, 0, 0, 0);
    tick();
    check("t2_next_valid", {31'd0, wb_valid}, 1);
    check("t2_next_data", wb_Data, 32'h77);
    idle_inputs();
    tick();

    // 3: store completing in first REQ cycle
    set_op(32'h44, 5'd2, 1, 0, 1, 32'h1234);
    tick();
    idle_inputs();
    check("t3_req", {31'd0, DC_req}, 1);
    check("t3_we", {31'd0, DC_we}, 1);
    check("t3_wdata", DC_wdata, 32'h1234);
    check("t3_addr", DC_addr, 32'h44);
    DC_ready = 1;
    tick();
    DC_ready = 0;
    check("t3_req_done", {31'd0, DC_req}, 0);
    check("t3_wb_valid", {31'd0, wb_valid}, 1);
    check("t3_wb_rw", {31'd0, wb_RegWrite}, 0);
    tick();
    check("t3_wb_pulse", {31'd0, wb_valid}, 0);

    // 4: flush on second of back-to-back R-types; branch resolution
    set_op(32'h11, 5'd4, 1, 0, 0, 0);
    tick();
    check("t4_first_valid", {31'd0, wb_valid}, 1);
    check("t4_first_data", wb_Data, 32'h11);
    set_op(32'h22, 5'd5, 1, 0, 0, 0);
    flush = 1;
    tick();
    check("t4_flush_bubble", {31'd0, wb_valid}, 0);
    idle_inputs();
    ex_valid = 1; ex_Branch = 1; Zero = 1;
    #1 check("t4_beq_taken", {31'd0, BranchTaken}, 1);
    Zero = 0;
    #1 check("t4_beq_not", {31'd0, BranchTaken}, 0);
    Zero = 1; flush = 1;
    #1 check("t4_beq_flush", {31'd0, BranchTaken}, 0);
    idle_inputs();
    tick();

    // 5: asynchronous reset mid-REQ
    set_op(32'h80, 5'd6, 1, 1, 0, 0);
    tick();
    idle_inputs();
    check("t5_req_before", {31'd0, DC_req}, 1);
    #2 rst = 1;
    #1;
    check("t5_req_rst", {31'd0, DC_req}, 0);
    check("t5_stall_rst", {31'd0, ex_stall}, 0);
    check("t5_wb_valid_rst", {31'd0, wb_valid}, 0);
    tick();
    rst = 0;
    set_op(32'h33, 5'd8, 1, 0, 0, 0);
    tick();
    check("t5_after_valid", {31'd0, wb_valid}, 1);
    check("t5_after_data", wb_Data, 32'h33);
    check("t5_after_wr", {27'd0, wb_WR}, 8);
    idle_inputs();
    tick();

    // 6: misaligned load at 0x42
    set_op(32'h42, 5'd10, 1, 1, 0, 0);
    tick();
    idle_inputs();
`ifdef EXMEM_MISALIGN_TRAP_EN
    check("t6_no_req", {31'd0, DC_req}, 0);
    check("t6_misalign", {31'd0, misalign}, 1);
    check("t6_wb_valid", {31'd0, wb_valid}, 1);
    check("t6_wb_rw", {31'd0, wb_RegWrite}, 0);
    tick();
    check("t6_misalign_pulse", {31'd0, misalign}, 0);
    check("t6_wb_pulse", {31'd0, wb_valid}, 0);
`else
    check("t6_req", {31'd0, DC_req}, 1);
    check("t6_addr", DC_addr, 32'h40);
    check("t6_misalign", {31'd0, misalign}, 0);
    DC_ready = 1; DC_rdata = 32'hCAFEF00D;
    tick();
    DC_ready = 0;
    check("t6_wb_valid", {31'd0, wb_valid}, 1);
    check("t6_wb_data", wb_Data, 32'hCAFEF00D);
    check("t6_wb_rw", {31'd0, wb_RegWrite}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
